// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int OVERSAMPLE = 16;

  // acc is the XOR of all transmitted data bits; odd parity inverts it.
  function automatic logic parity_level(input logic acc, input int mode);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer that drains the TX FIFO one word per frame,
// timed by an external 16x-oversampled baud tick.
//
// state  | meaning
// IDLE   | line high; pops a word as soon as the FIFO is non-empty
// START  | start bit (low) for 16 ticks
// DATA   | DBIT data bits, LSB first, 16 ticks each
// PARITY | optional parity bit, 16 ticks
// STOP   | line high for SB_TICK ticks, then done pulse
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam logic [4:0] TICK_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST  = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST   = 3'(DBIT - 1);
  localparam bit         HAS_PARITY = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);

  tx_state_t       state, state_n;
  logic [4:0]      tick_cnt, tick_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [DBIT-1:0] shift_reg, shift_n;
  logic            acc, acc_n;
  logic            done_n;
  logic            tx_n;

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    acc_n   = acc;
    fifo_rd = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        // A tick coincident with the pop is ignored: the counter starts at 0 in START.
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          shift_n = fifo_rdata;
          acc_n   = 1'b0;
          tick_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shift_n = shift_reg >> 1;
            acc_n   = acc ^ shift_reg[0];
            bit_n   = bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) begin
              state_n = HAS_PARITY ? PARITY : STOP;
            end
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_n  = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + 5'd1;
          end
        end
      end
      default: begin
        tick_n  = '0;
        state_n = IDLE;
      end
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = parity_level(acc_n, PARITY_MODE);
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      acc          <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      shift_reg    <= shift_n;
      acc          <= acc_n;
      tx           <= tx_n;
      tx_busy      <= (state_n != IDLE);
      tx_done_tick <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench: four DUT instances (no parity, even, odd, 2 stop bits)
// fed from queue-based FIFO models, with frames decoded off the tx line.
module tb_uart_tx_fifo_drain;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk    = 1'b0;
  logic       Reset  = 1'b1;
  logic       s_tick = 1'b0;
  logic       fifo_empty   [4];
  logic [7:0] fifo_rdata   [4];
  logic       fifo_rd      [4];
  logic       tx           [4];
  logic       tx_busy      [4];
  logic       tx_done_tick [4];

  logic [7:0] fq  [4][$];
  exp_t       exq [4][$];
  int pops  [4] = '{default: 0};
  int dones [4] = '{default: 0};
  int n_total = 0;
  int n_pass  = 0;
  int div = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div    = (div == 3) ? 0 : div + 1;
    s_tick = (div == 0);
  end

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY_MODE(0)) u_none (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .fifo_empty(fifo_empty[0]),
    .fifo_rdata(fifo_rdata[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]),
    .tx_busy(tx_busy[0]), .tx_done_tick(tx_done_tick[0]));
  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY_MODE(1)) u_even (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .fifo_empty(fifo_empty[1]),
    .fifo_rdata(fifo_rdata[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]),
    .tx_busy(tx_busy[1]), .tx_done_tick(tx_done_tick[1]));
  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .PARITY_MODE(2)) u_odd (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .fifo_empty(fifo_empty[2]),
    .fifo_rdata(fifo_rdata[2]), .fifo_rd(fifo_rd[2]), .tx(tx[2]),
    .tx_busy(tx_busy[2]), .tx_done_tick(tx_done_tick[2]));
  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .PARITY_MODE(0)) u_sb32 (
    .clk(clk), .Reset(Reset), .s_tick(s_tick), .fifo_empty(fifo_empty[3]),
    .fifo_rdata(fifo_rdata[3]), .fifo_rd(fifo_rd[3]), .tx(tx[3]),
    .tx_busy(tx_busy[3]), .tx_done_tick(tx_done_tick[3]));

  // FIFO models: the pop takes effect on the edge where fifo_rd is sampled high.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd[i] === 1'b1) begin
        pops[i]++;
        n_total++;
        if (fifo_empty[i] !== 1'b0)
          $display("FAIL pop_while_empty inst%0d: fifo_empty=%b required 0", i, fifo_empty[i]);
        else
          n_pass++;
        if (fq[i].size() > 0) void'(fq[i].pop_front());
      end
      if (tx_done_tick[i] === 1'b1) dones[i]++;
      fifo_empty[i] <= (fq[i].size() == 0);
      fifo_rdata[i] <= (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  end

  function automatic logic exp_par(input int i, input logic [7:0] v);
    case (i)
      1:       return ^v;
      2:       return ~(^v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input int i, input logic [7:0] v);
    exp_t e;
    e.d = v;
    e.p = exp_par(i, v);
    fq[i].push_back(v);
    exq[i].push_back(e);
  endtask

  // Decodes one frame from tx[i]; bit boundaries are the 16th (or sb-th) tick edge.
  task automatic rx_frame(input int i, input int sb, input bit has_par,
                          output logic [7:0] d, output logic p, output int wait_cyc,
                          output int bad_cyc, output int dmin, output int dmax,
                          output int stop_clk, output bit end_ok, output bit ok);
    int nbits, len, ticks, cyc;
    logic lvl;
    logic [10:0] bits;
    ok = 1'b1; bad_cyc = 0; dmin = 1 << 20; dmax = 0; stop_clk = 0;
    end_ok = 1'b0; d = '0; p = 1'b0; bits = '0; wait_cyc = 0;
    nbits = has_par ? 11 : 10;
    do begin
      @(posedge clk); #1;
      wait_cyc++;
    end while (tx[i] !== 1'b0 && wait_cyc < 300);
    if (tx[i] !== 1'b0) begin ok = 1'b0; return; end
    if (tx_busy[i] !== 1'b1) bad_cyc++;
    for (int b = 0; b < nbits; b++) begin
      len = (b == nbits - 1) ? sb : 16;
      lvl = tx[i];
      bits[b] = lvl;
      ticks = 0;
      cyc = 0;
      while (ticks < len && cyc < 1000) begin
        @(posedge clk); #1;
        cyc++;
        if (s_tick) ticks++;
        if (ticks < len && (tx[i] !== lvl || tx_busy[i] !== 1'b1 ||
                            fifo_rd[i] !== 1'b0 || tx_done_tick[i] !== 1'b0))
          bad_cyc++;
      end
      if (ticks < len) begin ok = 1'b0; return; end
      if (b >= 1 && b <= 8) begin
        if (cyc < dmin) dmin = cyc;
        if (cyc > dmax) dmax = cyc;
      end
      if (b == nbits - 1) stop_clk = cyc;
    end
    if (bits[nbits-1] !== 1'b1) bad_cyc++;
    end_ok = (tx_done_tick[i] === 1'b1 && tx[i] === 1'b1 && tx_busy[i] === 1'b0);
    d = bits[8:1];
    p = has_par ? bits[9] : 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (tx[i] !== 1'b1 || fifo_rd[i] !== 1'b0 || tx_busy[i] !== 1'b0 || tx_done_tick[i] !== 1'b0)
        $display("FAIL reset_values inst%0d: tx=%b rd=%b busy=%b done=%b required 1 0 0 0",
                 i, tx[i], fifo_rd[i], tx_busy[i], tx_done_tick[i]);
      else
        n_pass++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_idle;
    int bad_tx = 0, bad_rd = 0, bad_busy = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (tx[i] !== 1'b1) bad_tx++;
        if (fifo_rd[i] !== 1'b0) bad_rd++;
        if (tx_busy[i] !== 1'b0) bad_busy++;
      end
    end
    n_total++;
    if (bad_tx != 0) $display("FAIL idle_tx: %0d cycles not high, required 0", bad_tx); else n_pass++;
    n_total++;
    if (bad_rd != 0) $display("FAIL idle_rd: %0d cycles with pop, required 0", bad_rd); else n_pass++;
    n_total++;
    if (bad_busy != 0) $display("FAIL idle_busy: %0d busy cycles, required 0", bad_busy); else n_pass++;
  endtask

  task automatic test_single;
    logic [7:0] d; logic p; exp_t e;
    int w, bad, dmin, dmax, sc, p0, d0;
    bit eok, ok;
    p0 = pops[0]; d0 = dones[0];
    @(negedge clk);
    send(0, 8'h55);
    rx_frame(0, 16, 1'b0, d, p, w, bad, dmin, dmax, sc, eok, ok);
    e = exq[0].pop_front();
    n_total++;
    if (!ok) $display("FAIL single_timeout: frame not completed"); else n_pass++;
    n_total++;
    if (d !== e.d) $display("FAIL single_data: got %h required %h", d, e.d); else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL single_stable: %0d bad cycles, required 0", bad); else n_pass++;
    n_total++;
    if (dmin != 64 || dmax != 64)
      $display("FAIL single_bitlen: min %0d max %0d required 64", dmin, dmax);
    else n_pass++;
    n_total++;
    if (!eok) $display("FAIL single_end: done/tx/busy wrong at stop exit"); else n_pass++;
    @(negedge clk); @(negedge clk);
    n_total++;
    if (tx_done_tick[0] !== 1'b0) $display("FAIL single_done_width: done=%b required 0", tx_done_tick[0]);
    else n_pass++;
    n_total++;
    if (pops[0] - p0 != 1) $display("FAIL single_pops: %0d required 1", pops[0] - p0); else n_pass++;
    n_total++;
    if (dones[0] - d0 != 1) $display("FAIL single_dones: %0d required 1", dones[0] - d0); else n_pass++;
  endtask

  task automatic test_parity;
    logic [7:0] d; logic p; exp_t e;
    int w, bad, dmin, dmax, sc;
    bit eok, ok;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      send(i, 8'h07);
      rx_frame(i, 16, 1'b1, d, p, w, bad, dmin, dmax, sc, eok, ok);
      e = exq[i].pop_front();
      n_total++;
      if (!ok || d !== e.d) $display("FAIL parity_data inst%0d: got %h required %h", i, d, e.d);
      else n_pass++;
      n_total++;
      if (p !== e.p) $display("FAIL parity_bit inst%0d: got %b required %b", i, p, e.p); else n_pass++;
      n_total++;
      if (bad != 0 || !eok) $display("FAIL parity_frame inst%0d: bad=%0d end_ok=%b", i, bad, eok);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; logic p; exp_t e;
    int w, bad, dmin, dmax, sc, p0, d0;
    bit eok, ok;
    logic [7:0] words [3] = '{8'hA1, 8'h3C, 8'hFF};
    p0 = pops[0]; d0 = dones[0];
    @(negedge clk);
    for (int k = 0; k < 3; k++) send(0, words[k]);
    for (int k = 0; k < 3; k++) begin
      rx_frame(0, 16, 1'b0, d, p, w, bad, dmin, dmax, sc, eok, ok);
      e = exq[0].pop_front();
      n_total++;
      if (!ok || d !== e.d) $display("FAIL b2b_data%0d: got %h required %h", k, d, e.d); else n_pass++;
      n_total++;
      if (bad != 0 || !eok) $display("FAIL b2b_frame%0d: bad=%0d end_ok=%b", k, bad, eok); else n_pass++;
      if (k > 0) begin
        n_total++;
        if (w != 1) $display("FAIL b2b_gap%0d: %0d clk idle required 1", k, w); else n_pass++;
      end
    end
    @(negedge clk); @(negedge clk);
    n_total++;
    if (pops[0] - p0 != 3) $display("FAIL b2b_pops: %0d required 3", pops[0] - p0); else n_pass++;
    n_total++;
    if (dones[0] - d0 != 3) $display("FAIL b2b_dones: %0d required 3", dones[0] - d0); else n_pass++;
  endtask

  task automatic test_stop_bits;
    logic [7:0] d; logic p; exp_t e;
    int w, bad, dmin, dmax, sc;
    bit eok, ok;
    @(negedge clk);
    send(3, 8'h00);
    rx_frame(3, 32, 1'b0, d, p, w, bad, dmin, dmax, sc, eok, ok);
    e = exq[3].pop_front();
    n_total++;
    if (!ok || d !== e.d) $display("FAIL sb32_data: got %h required %h", d, e.d); else n_pass++;
    n_total++;
    if (sc != 128) $display("FAIL sb32_stop_len: %0d clk required 128", sc); else n_pass++;
    n_total++;
    if (bad != 0 || !eok) $display("FAIL sb32_frame: bad=%0d end_ok=%b", bad, eok); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int p0, c, bad;
    p0 = pops[0];
    @(negedge clk);
    send(0, 8'hF0);
    c = 0;
    do begin @(negedge clk); c++; end while (tx[0] !== 1'b0 && c < 300);
    repeat (192) @(negedge clk);
    n_total++;
    if (tx[0] !== 1'b0 || tx_busy[0] !== 1'b1)
      $display("FAIL midreset_pre: tx=%b busy=%b required 0 1", tx[0], tx_busy[0]);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++;
    if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0)
      $display("FAIL midreset_async: tx=%b busy=%b rd=%b required 1 0 0", tx[0], tx_busy[0], fifo_rd[0]);
    else n_pass++;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || tx_busy[0] !== 1'b0 || fifo_rd[0] !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL midreset_idle: %0d bad cycles required 0", bad); else n_pass++;
    n_total++;
    if (pops[0] - p0 != 1) $display("FAIL midreset_pops: %0d required 1", pops[0] - p0); else n_pass++;
    void'(exq[0].pop_front());
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_parity();
    test_back_to_back();
    test_stop_bits();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
